seg7_scan_ctrl: RTL and testbench

- Parametrised, time-multiplexed seven-segment display controller for FPGA builds of the MCU SoC.
- Successor to the fixed 8-digit controller; takes a packed hex word from debug/status logic and scans it onto common-anode digit and segment pins.
- Adds configurable digit count, anti-ghosting blank slot, leading-zero blanking, per-digit enable and decimal points.
- Adds a shadow register with load handshake so display values never tear mid-scan.

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_decoder.sv | 17 +
 rtl/seg7_scan_ctrl.sv | 179 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment scan controller.
//   seg_pattern_t : 7-bit active-high segment pattern {g,f,e,d,c,b,a}
//   SEG_HEX       : hex digit (0-F) to segment pattern lookup
//   scan_state_e  : per-slot scan phase (BLANK, ON)
package seg7_pkg;

    typedef logic [6:0] seg_pattern_t;

    localparam seg_pattern_t SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational hex nibble + decimal point to segment pattern.
//   nibble : hex value 0-F
//   dp     : decimal point (1 = lit)
//   seg    : active-high {dp,g,f,e,d,c,b,a}
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        seg = {dp, SEG_HEX[nibble]};
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed seven-segment display controller.
// Displays a shadowed packed hex word, one digit per slot; each slot starts with
// BLANK_CYCLES of all-anodes-off to suppress ghosting. Pins are registered.
//   clk, rst       : clock, asynchronous active-high reset
//   disp_data_i    : hex nibbles, nibble k -> digit k (digit 0 rightmost)
//   disp_dp_i      : decimal point per digit
//   digit_en_i     : per-digit enable
//   lzb_en_i       : leading-zero blanking enable
//   load_i         : capture inputs into shadow registers
//   load_ack_o     : one-cycle pulse after a capture
//   sev_cathode_o  : segments {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   sev_anode_o    : digit selects, polarity per AN_ACTIVE_LOW
//   digit_idx_o    : digit being scanned, aligned with sev_anode_o
// Optional: define SEG7_BRIGHTNESS_EN to add bright_i[3:0] (PWM within ON phase).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int SLOT_CYCLES    = 2500,
    parameter int BLANK_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] disp_data_i,
    input  logic [NUM_DIGITS-1:0]   disp_dp_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    input  logic                    lzb_en_i,
`ifdef SEG7_BRIGHTNESS_EN
    input  logic [3:0]              bright_i,
`endif
    input  logic                    load_i,
    output logic                    load_ack_o,
    output logic [7:0]              sev_cathode_o,
    output logic [NUM_DIGITS-1:0]   sev_anode_o,
    output logic [IDX_W-1:0]        digit_idx_o
);

    localparam int PS_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    logic [4*NUM_DIGITS-1:0] sh_data;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_en;
    logic                    sh_lzb;
`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0]              sh_bright;
    logic [31:0]             on_cnt;
`endif

    logic [PS_W-1:0]  ps, ps_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic             slot_last;
    scan_state_e      state, state_next;

    logic [3:0]       nib;
    logic             dp_bit, en_bit, lz_hit, zero_run, lit;
    logic [7:0]       seg_pat;

    logic [NUM_DIGITS-1:0] an_d, an_q;
    logic [7:0]            cat_d, cat_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  ack_q;

    // Shadow capture: the scan only ever reads these copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_data <= '0;
            sh_dp   <= '0;
            sh_en   <= '0;
            sh_lzb  <= 1'b0;
`ifdef SEG7_BRIGHTNESS_EN
            sh_bright <= '0;
`endif
            ack_q   <= 1'b0;
        end else begin
            ack_q <= load_i;
            if (load_i) begin
                sh_data <= disp_data_i;
                sh_dp   <= disp_dp_i;
                sh_en   <= digit_en_i;
                sh_lzb  <= lzb_en_i;
`ifdef SEG7_BRIGHTNESS_EN
                sh_bright <= bright_i;
`endif
            end
        end
    end

    // State register: prescaler, digit index and scan phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps    <= '0;
            idx   <= '0;
            state <= BLANK;
        end else begin
            ps    <= ps_next;
            idx   <= idx_next;
            state <= state_next;
        end
    end

    // Next-state logic; the phase is derived from the next prescaler value so
    // that state is always consistent with ps.
    always_comb begin
        slot_last = (ps == PS_W'(SLOT_CYCLES - 1));
        ps_next   = slot_last ? '0 : ps + PS_W'(1);
        idx_next  = idx;
        if (slot_last) begin
            idx_next = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end
        state_next = (int'(ps_next) < BLANK_CYCLES) ? BLANK : ON;
    end

    // Digit select plus leading-zero detection: walking from the MSB down,
    // zero_run stays set while every nibble seen so far is zero.
    always_comb begin
        nib      = '0;
        dp_bit   = 1'b0;
        en_bit   = 1'b0;
        lz_hit   = 1'b0;
        zero_run = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            zero_run = zero_run & (sh_data[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
            if (idx == IDX_W'(NUM_DIGITS - 1 - i)) begin
                nib    = sh_data[4*(NUM_DIGITS-1-i) +: 4];
                dp_bit = sh_dp[NUM_DIGITS-1-i];
                en_bit = sh_en[NUM_DIGITS-1-i];
                lz_hit = zero_run && (i != NUM_DIGITS - 1);
            end
        end
    end

    seg7_decoder u_dec (
        .nibble (nib),
        .dp     (dp_bit),
        .seg    (seg_pat)
    );

    // Output logic (active-high, pre-register).
    always_comb begin
        an_d  = '0;
        cat_d = '0;
        lit   = (state == ON) && en_bit && !(sh_lzb && lz_hit);
`ifdef SEG7_BRIGHTNESS_EN
        on_cnt = 32'(ps) - 32'(BLANK_CYCLES);
`endif
        if (lit) begin
            cat_d = seg_pat;
`ifdef SEG7_BRIGHTNESS_EN
            if (on_cnt[3:0] < sh_bright) begin
                an_d = NUM_DIGITS'(1) << idx;
            end
`else
            an_d = NUM_DIGITS'(1) << idx;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= '0;
            cat_q <= '0;
            idx_q <= '0;
        end else begin
            an_q  <= an_d;
            cat_q <= cat_d;
            idx_q <= idx;
        end
    end

    // Registers hold active-high values; pin polarity is applied here.
    assign sev_anode_o   = (AN_ACTIVE_LOW  != 0) ? ~an_q  : an_q;
    assign sev_cathode_o = (SEG_ACTIVE_LOW != 0) ? ~cat_q : cat_q;
    assign digit_idx_o   = idx_q;
    assign load_ack_o    = ack_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    localparam int N     = 8;
    localparam int SLOT  = 20;
    localparam int BLANK = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [4*N-1:0] disp_data_i = '0;
    logic [N-1:0]   disp_dp_i   = '0;
    logic [N-1:0]   digit_en_i  = '0;
    logic           lzb_en_i    = 1'b0;
    logic           load_i      = 1'b0;
`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0]     bright_i    = 4'd15;
`endif
    logic           load_ack_o;
    logic [7:0]     sev_cathode_o;
    logic [N-1:0]   sev_anode_o;
    logic [2:0]     digit_idx_o;

    seg7_scan_ctrl #(
        .NUM_DIGITS     (N),
        .SLOT_CYCLES    (SLOT),
        .BLANK_CYCLES   (BLANK),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .disp_data_i   (disp_data_i),
        .disp_dp_i     (disp_dp_i),
        .digit_en_i    (digit_en_i),
        .lzb_en_i      (lzb_en_i),
`ifdef SEG7_BRIGHTNESS_EN
        .bright_i      (bright_i),
`endif
        .load_i        (load_i),
        .load_ack_o    (load_ack_o),
        .sev_cathode_o (sev_cathode_o),
        .sev_anode_o   (sev_anode_o),
        .digit_idx_o   (digit_idx_o)
    );

    always #5 clk = ~clk;

    // Reference segment table, active-high {g..a}.
    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: m_cyc counts clock edges since reset release; the pins
    // after an edge show slot position (m_cyc mod SLOT) of digit
    // (m_cyc / SLOT) mod N, using the shadow values captured before that edge.
    int unsigned  m_cyc;
    logic [31:0]  m_data;
    logic [N-1:0] m_dp, m_en;
    logic         m_lzb;
    logic [3:0]   m_bright;
    logic [N-1:0] exp_an;
    logic [7:0]   exp_cat;
    logic [2:0]   exp_idx;
    logic         exp_ack;

    function automatic int digit_of(input int unsigned cyc);
        return (cyc % (N * SLOT)) / SLOT;
    endfunction

    function automatic bit digit_shown(input int unsigned cyc);
        int d = digit_of(cyc);
        int c = cyc % SLOT;
        bit blanked = !m_en[d] || (m_lzb && d != 0 && (m_data >> (4 * d)) == 0);
        return (c >= BLANK) && !blanked;
    endfunction

    function automatic bit anode_on(input int unsigned cyc);
        bit on = digit_shown(cyc);
`ifdef SEG7_BRIGHTNESS_EN
        on = on && (((cyc % SLOT) - BLANK) % 16 < m_bright);
`endif
        return on;
    endfunction

    function automatic logic [7:0] model_cat(input int unsigned cyc);
        int d = digit_of(cyc);
        logic [3:0] nb = 4'((m_data >> (4 * d)) & 32'hF);
        return digit_shown(cyc) ? ~{m_dp[d], hex_tab[nb]} : 8'hFF;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc    <= 0;
            m_data   <= '0;
            m_dp     <= '0;
            m_en     <= '0;
            m_lzb    <= 1'b0;
            m_bright <= '0;
            exp_an   <= '1;
            exp_cat  <= '1;
            exp_idx  <= '0;
            exp_ack  <= 1'b0;
        end else begin
            exp_an  <= anode_on(m_cyc) ? ~(N'(1) << digit_of(m_cyc)) : '1;
            exp_cat <= model_cat(m_cyc);
            exp_idx <= 3'(digit_of(m_cyc));
            exp_ack <= load_i;
            if (load_i) begin
                m_data <= disp_data_i;
                m_dp   <= disp_dp_i;
                m_en   <= digit_en_i;
                m_lzb  <= lzb_en_i;
`ifdef SEG7_BRIGHTNESS_EN
                m_bright <= bright_i;
`endif
            end
            m_cyc <= m_cyc + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_pins();
        check("anode", 64'(sev_anode_o), 64'(exp_an));
        check("cathode", 64'(sev_cathode_o), 64'(exp_cat));
        check("idx", 64'(digit_idx_o), 64'(exp_idx));
        check("ack", 64'(load_ack_o), 64'(exp_ack));
    endtask

    // One clock edge, then compare on the falling edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check_pins();
        end
    endtask

    task automatic do_load(input logic [31:0] d, input logic [N-1:0] dp,
                           input logic [N-1:0] en, input logic lzb, input int hold = 1);
        disp_data_i = d;
        disp_dp_i   = dp;
        digit_en_i  = en;
        lzb_en_i    = lzb;
`ifdef SEG7_BRIGHTNESS_EN
        bright_i    = 4'($urandom_range(0, 15));
`endif
        load_i = 1'b1;
        tick(hold);
        load_i = 1'b0;
        tick();
    endtask

    // Advance until digit d is lit, then compare its cathodes with a constant.
    task automatic expect_digit(input int d, input logic [7:0] cat, input string tag);
        bit found = 0;
        for (int i = 0; i < 2 * N * SLOT && !found; i++) begin
            tick();
            if (int'(digit_idx_o) == d && sev_anode_o != '1) found = 1;
        end
        check({tag, "_seen"}, 64'(found), 64'd1);
        if (found) check(tag, 64'(sev_cathode_o), 64'(cat));
    endtask

    initial begin
        // Outputs inactive throughout reset.
        repeat (3) begin
            @(negedge clk);
            check("rst_anode", 64'(sev_anode_o), 64'hFF);
            check("rst_cathode", 64'(sev_cathode_o), 64'hFF);
            check("rst_idx", 64'(digit_idx_o), 64'd0);
        end
        rst = 1'b0;

        // Idle scan over a full refresh period plus wrap.
        tick(N * SLOT + 10);

        // Mixed digits with dp on digit 0.
        do_load(32'h1234ABCD, 8'h01, 8'hFF, 1'b0);
`ifndef SEG7_BRIGHTNESS_EN
        expect_digit(0, 8'h21, "d0_dp");
        expect_digit(7, 8'hF9, "d7_one");
`endif
        tick(N * SLOT);

        // Leading-zero blanking.
        do_load(32'h00000050, 8'h00, 8'hFF, 1'b1);
`ifndef SEG7_BRIGHTNESS_EN
        expect_digit(1, 8'h92, "lzb_d1");
        expect_digit(0, 8'hC0, "lzb_d0");
`endif
        tick(N * SLOT);
        do_load(32'h00000000, 8'hFF, 8'hFF, 1'b1);
        tick(N * SLOT);

        // Random shadow contents, some held loads.
        for (int unsigned r = 0; r < 24; r++) begin
            do_load($urandom >> (4 * $urandom_range(0, 8)), N'($urandom),
                    ($urandom_range(0, 3) == 0) ? N'($urandom) : '1,
                    1'($urandom), $urandom_range(1, 3));
            tick($urandom_range(5, 60));
        end

        // Mid-scan load during digit 3's ON phase.
        do_load(32'h87654321, 8'hF0, 8'hFF, 1'b0);
        begin
            bit found = 0;
            for (int i = 0; i < 2 * N * SLOT && !found; i++) begin
                tick();
                if (digit_idx_o == 3'd3 && (m_cyc % SLOT) > BLANK + 2) found = 1;
            end
            check("mid_load_seen", 64'(found), 64'd1);
        end
        do_load(32'hFEDCBA98, 8'h0F, 8'hFF, 1'b0);
        tick(N * SLOT);

        // Asynchronous reset pulsed mid-slot.
        tick(7);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_anode", 64'(sev_anode_o), 64'hFF);
        check("arst_cathode", 64'(sev_cathode_o), 64'hFF);
        check("arst_idx", 64'(digit_idx_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(30);
        do_load(32'h0000CAFE, 8'h05, 8'hFF, 1'b1);
        tick(N * SLOT);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
